// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-detection inputs and pipeline control outputs shared between the
// pipeline datapath (master) and the hazard/sequencing controller (slave).
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             id_ex_memread;
   logic [4:0]       id_ex_rd;
   logic [4:0]       if_id_rs1;
   logic [4:0]       if_id_rs2;
   logic             ex_mem_branch;
   logic             ex_mem_zero;
   logic             halt_req;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             halt_ack;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2,
             ex_mem_branch, ex_mem_zero, halt_req,
      input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
             halt_ack, state, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2,
             ex_mem_branch, ex_mem_zero, halt_req,
      output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
             halt_ack, state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, taken-branch squash and halt drain/freeze sequencing for the
// 5-stage core, with saturating stall and flush event counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   pipeline_hazard_ctrl_if.slave  hz
);

   localparam int unsigned DW = 4;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic             halt_ack_q, halt_ack_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic load_use;
   logic taken;
   logic stall_inc;
   logic flush_inc;

   assign load_use = hz.id_ex_memread && (hz.id_ex_rd != 5'd0) &&
                     ((hz.id_ex_rd == hz.if_id_rs1) || (hz.id_ex_rd == hz.if_id_rs2));
   assign taken    = hz.ex_mem_branch && hz.ex_mem_zero;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         drain_q     <= '0;
         halt_ack_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         halt_ack_q  <= halt_ack_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next-state and pipeline control decode; the unused encoding behaves as RUN.
   always_comb begin
      state_d         = state_q;
      drain_d         = drain_q;
      hz.pc_write     = 1'b1;
      hz.if_id_write  = 1'b1;
      hz.if_id_flush  = 1'b0;
      hz.id_ex_flush  = 1'b0;
      hz.ex_mem_flush = 1'b0;
      stall_inc       = 1'b0;
      flush_inc       = 1'b0;

      case (state_q)
         ST_DRAIN: begin
            hz.if_id_flush  = 1'b1;
            hz.pc_write     = taken;
            hz.id_ex_flush  = taken;
            hz.ex_mem_flush = taken;
            flush_inc       = taken;
            if (!hz.halt_req) begin
               state_d = ST_RUN;
            end else if (drain_q == '0) begin
               state_d = ST_HALTED;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end

         ST_HALTED: begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
            if (!hz.halt_req) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_RUN;
            if (taken) begin
               hz.if_id_flush  = 1'b1;
               hz.id_ex_flush  = 1'b1;
               hz.ex_mem_flush = 1'b1;
               flush_inc       = 1'b1;
            end else if (load_use) begin
               hz.pc_write    = 1'b0;
               hz.if_id_write = 1'b0;
               hz.id_ex_flush = 1'b1;
               stall_inc      = 1'b1;
            end
            if (hz.halt_req) begin
               state_d = ST_DRAIN;
               drain_d = DW'(DRAIN_CYCLES - 1);
            end
         end
      endcase

      halt_ack_d  = (state_d == ST_HALTED);
      stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end

   assign hz.halt_ack  = halt_ack_q;
   assign hz.state     = state_q;
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a queue-based scoreboard.
module tb_pipeline_hazard_ctrl;

   typedef struct {
      int          tag;
      logic [15:0] vec;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic done  = 1'b0;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_cyc  = 0;
   int   n_tag  = 0;
   int   n_idle = 0;

   pipeline_hazard_ctrl_if #(.CNT_W(4)) hz_if ();

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz_if)
   );

   always #5 clk = ~clk;

   // c = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
   task automatic cyc(input logic r, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic br, input logic z, input logic h,
                      input logic [4:0] c, input logic a, input logic [1:0] st,
                      input logic [3:0] s, input logic [3:0] f);
      exp_t e;
      reset                = r;
      hz_if.id_ex_memread  = mr;
      hz_if.id_ex_rd       = rd;
      hz_if.if_id_rs1      = rs1;
      hz_if.if_id_rs2      = rs2;
      hz_if.ex_mem_branch  = br;
      hz_if.ex_mem_zero    = z;
      hz_if.halt_req       = h;
      e.tag = n_tag;
      e.vec = {c, a, st, s, f};
      exp_q.push_back(e);
      n_tag++;
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops and compares at each falling edge when an expectation is pending.
   always @(negedge clk) begin
      logic [15:0] act;
      exp_t        e;
      n_cyc++;
      act = {hz_if.pc_write, hz_if.if_id_write, hz_if.if_id_flush, hz_if.id_ex_flush,
             hz_if.ex_mem_flush, hz_if.halt_ack, hz_if.state, hz_if.stall_cnt, hz_if.flush_cnt};
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (act !== e.vec) begin
            n_fail++;
            $display("FAIL vec%0d ctl/ack/st/stall/flush got %b_%b_%b_%h_%h required %b_%b_%b_%h_%h",
                     e.tag, act[15:11], act[10], act[9:8], act[7:4], act[3:0],
                     e.vec[15:11], e.vec[10], e.vec[9:8], e.vec[7:4], e.vec[3:0]);
         end
      end
      if (done) n_idle++;
      if ((done && exp_q.size() == 0) || n_idle > 10 || n_cyc > 5000) begin
         if (exp_q.size() != 0 || !done) begin
            n_fail++;
            $display("FAIL timeout pending=%0d required 0", exp_q.size());
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
         $finish;
      end
   end

   initial begin
      hz_if.id_ex_memread = 1'b0;
      hz_if.id_ex_rd      = '0;
      hz_if.if_id_rs1     = '0;
      hz_if.if_id_rs2     = '0;
      hz_if.ex_mem_branch = 1'b0;
      hz_if.ex_mem_zero   = 1'b0;
      hz_if.halt_req      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      //  r  mr rd  rs1 rs2 br z  h   ctl      ack st  stall flush
      cyc(1, 0, 0,  0,  0,  0, 0, 0, 5'b11000, 0, 0, 0, 0);   // reset held
      cyc(0, 0, 0,  0,  0,  0, 0, 0, 5'b11000, 0, 0, 0, 0);
      cyc(0, 1, 5,  0,  5,  0, 0, 0, 5'b00010, 0, 0, 0, 0);   // load-use via rs2
      cyc(0, 0, 0,  0,  0,  0, 0, 0, 5'b11000, 0, 0, 1, 0);
      cyc(0, 1, 0,  0,  0,  0, 0, 0, 5'b11000, 0, 0, 1, 0);   // x0 never stalls
      cyc(0, 1, 7,  7,  3,  0, 0, 0, 5'b00010, 0, 0, 1, 0);   // load-use via rs1
      cyc(0, 0, 7,  7,  3,  0, 0, 0, 5'b11000, 0, 0, 2, 0);   // not a load
      cyc(0, 1, 5,  0,  5,  1, 1, 0, 5'b11111, 0, 0, 2, 0);   // taken beats load-use
      cyc(0, 0, 0,  0,  0,  1, 0, 0, 5'b11000, 0, 0, 2, 1);   // not taken
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b11000, 0, 0, 2, 1);   // halt_req rises (N)
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b01100, 0, 1, 2, 1);   // N+1 DRAIN
      cyc(0, 1, 5,  5,  0,  1, 1, 1, 5'b11111, 0, 1, 2, 1);   // N+2 taken in DRAIN
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b01100, 0, 1, 2, 2);   // N+3
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b01100, 0, 1, 2, 2);   // N+4
      cyc(0, 0, 0,  0,  0,  1, 1, 1, 5'b00110, 1, 2, 2, 2);   // N+5 HALTED, taken ignored
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b00110, 1, 2, 2, 2);
      cyc(0, 0, 0,  0,  0,  0, 0, 0, 5'b00110, 1, 2, 2, 2);   // halt_req falls
      cyc(0, 0, 0,  0,  0,  0, 0, 0, 5'b11000, 0, 0, 2, 2);   // back to RUN
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b11000, 0, 0, 2, 2);   // abort sequence
      cyc(0, 0, 0,  0,  0,  0, 0, 0, 5'b01100, 0, 1, 2, 2);
      cyc(0, 0, 0,  0,  0,  0, 0, 0, 5'b11000, 0, 0, 2, 2);
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b11000, 0, 0, 2, 2);   // halt again
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b01100, 0, 1, 2, 2);
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b01100, 0, 1, 2, 2);
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b01100, 0, 1, 2, 2);
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b01100, 0, 1, 2, 2);
      cyc(0, 0, 0,  0,  0,  0, 0, 1, 5'b00110, 1, 2, 2, 2);
      cyc(1, 0, 0,  0,  0,  0, 0, 1, 5'b11000, 0, 0, 0, 0);   // async reset while HALTED
      cyc(0, 0, 0,  0,  0,  0, 0, 0, 5'b11000, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(0, 1, 9, 9, 2, 0, 0, 0, 5'b00010, 0, 0, (i > 15) ? 4'd15 : 4'(i), 0);
      end
      cyc(0, 0, 0,  0,  0,  0, 0, 0, 5'b11000, 0, 0, 15, 0);  // saturated
      done = 1'b1;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipelined RV64 core. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and the program counter, and drives their write-enable and flush controls. It inserts one bubble on a load-use hazard and squashes wrong-path instructions when a branch resolves taken in MEM. It also drains and freezes the pipeline on an external halt request and keeps saturating stall and flush event counters.

## Interface
Parameters:
- DRAIN_CYCLES, 4, cycles spent in DRAIN before the pipeline counts as empty (range 1..15)
- CNT_W, 32, width of each event counter

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rd  in  5  destination register of the instruction in EX
- if_id_rs1  in  5  rs1 of the instruction in ID
- if_id_rs2  in  5  rs2 of the instruction in ID
- ex_mem_branch  in  1  instruction in MEM is a branch
- ex_mem_zero  in  1  ALU zero flag registered with that branch
- halt_req  in  1  level request to freeze the core
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID hold when 0
- if_id_flush  out  1  IF/ID loads a bubble (all zeros)
- id_ex_flush  out  1  ID/EX control bits cleared
- ex_mem_flush  out  1  EX/MEM control bits cleared
- halt_ack  out  1  registered; pipeline is empty and frozen
- state  out  2  RUN=0, DRAIN=1, HALTED=2
- stall_cnt  out  CNT_W  load-use stalls taken, saturating
- flush_cnt  out  CNT_W  taken-branch flushes, saturating

## Operation
- Hazard decode (combinational):
  - load_use = id_ex_memread & (id_ex_rd != 0) & ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2))
  - taken = ex_mem_branch & ex_mem_zero
- RUN:
  - taken: pc_write=1; if_id_flush=id_ex_flush=ex_mem_flush=1; if_id_write=1. Taken has priority over load_use, which is ignored that cycle.
  - else load_use: pc_write=0, if_id_write=0, id_ex_flush=1, other flushes 0.
  - else all enables 1, all flushes 0.
  - halt_req=1: next state DRAIN, drain counter loaded with DRAIN_CYCLES-1. A taken branch in the same cycle is still applied.
- DRAIN:
  - if_id_flush=1 every cycle, so no new instruction enters.
  - pc_write=1 only when taken, so the PC captures the redirect target. Otherwise pc_write=0.
  - id_ex_flush and ex_mem_flush follow taken. load_use is ignored, because ID already holds a bubble.
  - The counter decrements each cycle. At 0 the next state is HALTED. halt_req deasserting in DRAIN returns to RUN next cycle.
- HALTED:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_flush=0.
  - halt_ack=1 from the first HALTED cycle.
  - halt_req=0: next state RUN, with halt_ack=0 in the same edge.
- Counters:
  - stall_cnt increments on each RUN cycle where load_use & !taken.
  - flush_cnt increments on each cycle where taken, in RUN or DRAIN.
  - Both saturate at 2^CNT_W-1.
- Register x0 never causes a stall.
- The state value 3 is illegal; it decodes as RUN and transitions to RUN.

## Timing
- Reset values: state=RUN, drain counter=0, halt_ack=0, stall_cnt=0, flush_cnt=0. Combinational outputs follow RUN decode while reset is held.
- Hazard outputs are combinational, with zero latency from inputs in the same cycle.
- A load-use stall lasts exactly one cycle. On the next edge the load moves to MEM and load_use clears through forwarding.
- Branch flush lasts one cycle. The first target instruction is fetched the cycle after taken.
- halt_req rising in cycle N:
  - DRAIN occupies cycles N+1 through N+DRAIN_CYCLES.
  - HALTED and halt_ack=1 start in cycle N+DRAIN_CYCLES+1.
- halt_req falling while HALTED: RUN and halt_ack=0 in the next cycle. Fetch resumes from the held PC.
- Reset asserted mid-DRAIN or mid-HALTED: state returns to RUN and halt_ack falls asynchronously.

## Test plan
- Load-use stall: ld x5 in EX (id_ex_memread=1, id_ex_rd=5) with if_id_rs2=5 -> pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle; stall_cnt goes 0->1. Repeat with id_ex_rd=0 -> no stall.
- Taken branch: ex_mem_branch=1, ex_mem_zero=1 together with a concurrent load_use -> all three flushes=1, pc_write=1, stall_cnt unchanged, flush_cnt +1. With ex_mem_zero=0 -> no flush.
- Halt sequence with DRAIN_CYCLES=4: halt_req=1 at cycle 10 -> state=1 in cycles 11-14, state=2 and halt_ack=1 at cycle 15. Drop halt_req at cycle 20 -> state=0, halt_ack=0 at cycle 21.
- Branch during DRAIN: taken at the second DRAIN cycle -> pc_write=1 for that cycle only, ex_mem_flush=1, HALTED still entered on schedule.
- Abort and reset: halt_req drops in DRAIN -> RUN next cycle, halt_ack never rises. Asynchronous reset pulse while HALTED -> state=0, halt_ack=0 before the next edge, counters=0.
- Saturation with CNT_W=4: 20 consecutive load-use stalls -> stall_cnt holds at 15.
